// File: rtl/branch_stream_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_stream_gen_pkg
//  Description : Shared types and default widths for the branch stream
//                generator and its scoreboard.
//                - state_e    : generator FSM state encoding
//                - DEF_CNT_W  : default width of loop counts and counters
//                - DEF_STAT_W : default width of statistics counters
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_stream_gen_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_STAT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_BODY  = 3'd2,
        ST_EXIT  = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_stream_gen_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : branch_scoreboard
//  Description : Saturating hit/miss statistics for a branch predictor
//                driver. Every cycle with valid_i high scores one branch by
//                comparing prediction_i with result_i. clear_i zeroes all
//                counters and takes priority over scoring.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                clear_i             - synchronous clear of all counters
//                valid_i             - a branch is issued this cycle
//                prediction_i        - predictor output for the branch
//                result_i            - actual branch outcome
//                branches_o/hits_o/misses_o - registered statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_scoreboard
    import branch_stream_gen_pkg::*;
#(
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic              prediction_i,
    input  logic              result_i,
    output logic [STAT_W-1:0] branches_o,
    output logic [STAT_W-1:0] hits_o,
    output logic [STAT_W-1:0] misses_o
);

    logic [STAT_W-1:0] branches_q, branches_d;
    logic [STAT_W-1:0] hits_q,     hits_d;
    logic [STAT_W-1:0] misses_q,   misses_d;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    always_comb begin
        branches_d = branches_q;
        hits_d     = hits_q;
        misses_d   = misses_q;
        if (clear_i) begin
            branches_d = '0;
            hits_d     = '0;
            misses_d   = '0;
        end else if (valid_i) begin
            branches_d = sat_inc(branches_q);
            if (prediction_i == result_i) begin
                hits_d = sat_inc(hits_q);
            end else begin
                misses_d = sat_inc(misses_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q <= '0;
            hits_q     <= '0;
            misses_q   <= '0;
        end else begin
            branches_q <= branches_d;
            hits_q     <= hits_d;
            misses_q   <= misses_d;
        end
    end

    assign branches_o = branches_q;
    assign hits_o     = hits_q;
    assign misses_o   = misses_q;

endmodule
`default_nettype wire

// File: rtl/branch_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : branch_stream_gen
//  Description : Synthesizable nested-loop branch stream generator. Per outer
//                iteration it issues one head branch (taken), inner_count
//                loop branches (taken) and one loop-exit branch (not taken);
//                one final head branch (not taken) ends the run. The
//                predictor's answer is scored on every issue cycle.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                start                      - run request, accepted in idle
//                outer_count/inner_count    - loop counts, sampled on start
//                busy, done                 - run status
//                cs, enable, branch_address, branch_result - predictor drive
//                prediction                 - predictor output
//                total_branches/hits/misses - saturating run statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_stream_gen
    import branch_stream_gen_pkg::*;
#(
    parameter int ADDR_W    = 1,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int STAT_W    = DEF_STAT_W,
    parameter int ADDR_HEAD = 0,
    parameter int ADDR_LOOP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  outer_count,
    input  logic [CNT_W-1:0]  inner_count,
    output logic              busy,
    output logic              done,
    output logic              cs,
    output logic              enable,
    output logic [ADDR_W-1:0] branch_address,
    output logic              branch_result,
    input  logic              prediction,
    output logic [STAT_W-1:0] total_branches,
    output logic [STAT_W-1:0] total_hits,
    output logic [STAT_W-1:0] total_misses
);

    localparam logic [ADDR_W-1:0] c_addr_head = ADDR_W'(ADDR_HEAD);
    localparam logic [ADDR_W-1:0] c_addr_loop = ADDR_W'(ADDR_LOOP);
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  outer_rem_q;   // outer iterations still to finish
    logic [CNT_W-1:0]  inner_lat_q;   // inner count latched at start
    logic [CNT_W-1:0]  inner_rem_q;   // loop branches left in this iteration
    logic              busy_q;
    logic              done_q;
    logic              cs_q;
    logic              enable_q;
    logic [ADDR_W-1:0] addr_q;
    logic              result_q;

    logic              w_accept;

    assign w_accept = (state_q == ST_IDLE) && start;

    // state_q names the branch currently on the outputs; each transition
    // loads the outputs for the branch of the state being entered, so all
    // predictor-facing signals come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            outer_rem_q <= '0;
            inner_lat_q <= '0;
            inner_rem_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            enable_q    <= 1'b0;
            addr_q      <= '0;
            result_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        outer_rem_q <= outer_count;
                        inner_lat_q <= inner_count;
                        busy_q      <= 1'b1;
                        cs_q        <= 1'b1;
                        enable_q    <= 1'b1;
                        addr_q      <= c_addr_head;
                        if (outer_count != '0) begin
                            state_q  <= ST_HEAD;
                            result_q <= 1'b1;
                        end else begin
                            state_q  <= ST_FINAL;
                            result_q <= 1'b0;
                        end
                    end
                end

                ST_HEAD: begin
                    addr_q <= c_addr_loop;
                    if (inner_lat_q != '0) begin
                        state_q     <= ST_BODY;
                        inner_rem_q <= inner_lat_q;
                        result_q    <= 1'b1;
                    end else begin
                        state_q  <= ST_EXIT;
                        result_q <= 1'b0;
                    end
                end

                // Counting down to one (not zero) lets an all-ones inner
                // count run its full length without a wrap.
                ST_BODY: begin
                    if (inner_rem_q == c_cnt_one) begin
                        state_q  <= ST_EXIT;
                        result_q <= 1'b0;
                    end else begin
                        inner_rem_q <= inner_rem_q - c_cnt_one;
                    end
                end

                ST_EXIT: begin
                    outer_rem_q <= outer_rem_q - c_cnt_one;
                    addr_q      <= c_addr_head;
                    if (outer_rem_q == c_cnt_one) begin
                        state_q  <= ST_FINAL;
                        result_q <= 1'b0;
                    end else begin
                        state_q  <= ST_HEAD;
                        result_q <= 1'b1;
                    end
                end

                ST_FINAL: begin
                    state_q  <= ST_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    cs_q     <= 1'b0;
                    enable_q <= 1'b0;
                    addr_q   <= '0;
                    result_q <= 1'b0;
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    cs_q     <= 1'b0;
                    enable_q <= 1'b0;
                    addr_q   <= '0;
                    result_q <= 1'b0;
                end
            endcase
        end
    end

    branch_scoreboard #(
        .STAT_W (STAT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (w_accept),
        .valid_i      (enable_q),
        .prediction_i (prediction),
        .result_i     (result_q),
        .branches_o   (total_branches),
        .hits_o       (total_hits),
        .misses_o     (total_misses)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign cs             = cs_q;
    assign enable         = enable_q;
    assign branch_address = addr_q;
    assign branch_result  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_stream_gen
//  Description : Directed self-checking bench for branch_stream_gen.
//                u_dut  : main instance, bench-driven predictor
//                u_dutz : same inputs, prediction tied low
//                u_duts : 4-bit statistics build, prediction tied low
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] outer_count = '0;
    logic [15:0] inner_count = '0;

    logic        busy, done, cs, enable, branch_result, prediction;
    logic [0:0]  branch_address;
    logic [31:0] total_branches, total_hits, total_misses;

    logic        z_busy, z_done, z_cs, z_enable, z_result;
    logic [0:0]  z_addr;
    logic [31:0] z_branches, z_hits, z_misses;

    logic        s_start = 1'b0;
    logic [15:0] s_outer = '0;
    logic [15:0] s_inner = '0;
    logic        s_busy, s_done, s_cs, s_enable, s_result;
    logic [0:0]  s_addr;
    logic [3:0]  s_branches, s_hits, s_misses;

    // 0: predict not-taken, 1: predict taken, 2: 2-bit saturating model
    logic [1:0]  pred_mode = 2'd1;
    logic [1:0]  ctr [2] = '{2'b00, 2'b00};

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int run_hits;
    int d0;

    logic [0:0]  exp_addr [$];
    logic        exp_res  [$];

    always #5 clk = ~clk;

    branch_stream_gen u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .outer_count(outer_count), .inner_count(inner_count),
        .busy(busy), .done(done), .cs(cs), .enable(enable),
        .branch_address(branch_address), .branch_result(branch_result),
        .prediction(prediction),
        .total_branches(total_branches), .total_hits(total_hits),
        .total_misses(total_misses)
    );

    branch_stream_gen u_dutz (
        .clk(clk), .rst_n(rst_n), .start(start),
        .outer_count(outer_count), .inner_count(inner_count),
        .busy(z_busy), .done(z_done), .cs(z_cs), .enable(z_enable),
        .branch_address(z_addr), .branch_result(z_result),
        .prediction(1'b0),
        .total_branches(z_branches), .total_hits(z_hits),
        .total_misses(z_misses)
    );

    branch_stream_gen #(.STAT_W(4)) u_duts (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .outer_count(s_outer), .inner_count(s_inner),
        .busy(s_busy), .done(s_done), .cs(s_cs), .enable(s_enable),
        .branch_address(s_addr), .branch_result(s_result),
        .prediction(1'b0),
        .total_branches(s_branches), .total_hits(s_hits),
        .total_misses(s_misses)
    );

    assign prediction = (pred_mode == 2'd2) ? ctr[branch_address][1] : pred_mode[0];

    always @(posedge clk) begin
        if (enable && pred_mode == 2'd2) begin
            if (branch_result)
                ctr[branch_address] <= (ctr[branch_address] == 2'd3) ? 2'd3 : ctr[branch_address] + 2'd1;
            else
                ctr[branch_address] <= (ctr[branch_address] == 2'd0) ? 2'd0 : ctr[branch_address] - 2'd1;
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [15:0] o, input logic [15:0] i);
        @(posedge clk); #1;
        outer_count = o;
        inner_count = i;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int k;
        k = 0;
        while (!done && k < max) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic add_br(input logic [0:0] a, input logic r);
        exp_addr.push_back(a);
        exp_res.push_back(r);
    endtask

    // Walks the expected branch list one clock at a time from the first
    // issue cycle, checking outputs and running statistics.
    task automatic check_seq(input string tag);
        run_hits = 0;
        for (int i = 0; i < exp_addr.size(); i++) begin
            chk($sformatf("%s_en[%0d]", tag, i), enable, 1);
            chk($sformatf("%s_addr[%0d]", tag, i), branch_address, exp_addr[i]);
            chk($sformatf("%s_res[%0d]", tag, i), branch_result, exp_res[i]);
            chk($sformatf("%s_nbr[%0d]", tag, i), total_branches, i);
            chk($sformatf("%s_nhit[%0d]", tag, i), total_hits, run_hits);
            if (prediction == exp_res[i]) run_hits++;
            @(posedge clk); #1;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", cs, 0);
        chk("rst_enable", enable, 0);
        chk("rst_addr", branch_address, 0);
        chk("rst_res", branch_result, 0);
        chk("rst_branches", total_branches, 0);
        chk("rst_misses", total_misses, 0);
        rst_n = 1'b1;

        // long run, taken predictor on u_dut and not-taken on u_dutz
        pred_mode = 2'd1;
        d0 = done_cnt;
        start_run(16'd40, 16'd1000);
        chk("long_busy", busy, 1);
        chk("long_first_addr", branch_address, 0);
        chk("long_first_res", branch_result, 1);
        wait_done(41000, "long");
        chk("long_branches", total_branches, 40081);
        chk("long_hits", total_hits, 40040);
        chk("long_misses", total_misses, 41);
        chk("long0_branches", z_branches, 40081);
        chk("long0_hits", z_hits, 41);
        chk("long0_misses", z_misses, 40040);
        repeat (3) @(posedge clk);
        #1;
        chk("long_done_pulses", done_cnt - d0, 1);
        chk("long_hold", total_branches, 40081);

        // outer = 0: a lone final branch
        pred_mode = 2'd0;
        exp_addr.delete(); exp_res.delete();
        add_br(1'b0, 1'b0);
        start_run(16'd0, 16'd5);
        check_seq("outer0");
        chk("outer0_branches", total_branches, 1);
        chk("outer0_hits", total_hits, 1);

        // outer = 3, inner = 0
        exp_addr.delete(); exp_res.delete();
        for (int i = 0; i < 3; i++) begin
            add_br(1'b0, 1'b1);
            add_br(1'b1, 1'b0);
        end
        add_br(1'b0, 1'b0);
        start_run(16'd3, 16'd0);
        check_seq("inner0");
        chk("inner0_branches", total_branches, 7);
        chk("inner0_misses", total_misses, 3);

        // 2-bit predictor model, outer = 2, inner = 4
        pred_mode = 2'd2;
        exp_addr.delete(); exp_res.delete();
        for (int o = 0; o < 2; o++) begin
            add_br(1'b0, 1'b1);
            for (int i = 0; i < 4; i++) add_br(1'b1, 1'b1);
            add_br(1'b1, 1'b0);
        end
        add_br(1'b0, 1'b0);
        start_run(16'd2, 16'd4);
        check_seq("model");
        chk("model_branches", total_branches, 13);
        chk("model_hits", total_hits, 6);
        chk("model_misses", total_misses, 7);

        // start while busy is ignored, and count inputs changing mid-run
        pred_mode = 2'd1;
        start_run(16'd2, 16'd3);
        repeat (3) @(posedge clk);
        #1;
        outer_count = 16'd5;
        inner_count = 16'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, "busy_start");
        chk("busy_start_branches", total_branches, 11);
        chk("busy_start_hits", total_hits, 8);
        chk("busy_start_misses", total_misses, 3);

        // reset in the middle of the loop body
        start_run(16'd3, 16'd10);
        repeat (4) @(posedge clk);
        #2;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cs", cs, 0);
        chk("abort_enable", enable, 0);
        chk("abort_addr", branch_address, 0);
        chk("abort_branches", total_branches, 0);
        chk("abort_hits", total_hits, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);

        // fresh run after the abort
        start_run(16'd1, 16'd2);
        wait_done(50, "fresh");
        chk("fresh_branches", total_branches, 5);
        chk("fresh_hits", total_hits, 3);
        chk("fresh_misses", total_misses, 2);

        // saturation in the 4-bit statistics build
        @(posedge clk); #1;
        s_outer = 16'd1;
        s_inner = 16'd20;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        begin
            int k;
            k = 0;
            while (!s_done && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("sat_done", s_done, 1);
        chk("sat_branches", s_branches, 15);
        chk("sat_misses", s_misses, 15);
        chk("sat_hits", s_hits, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
